// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port register file. It has NRD combinational
//            read ports, two registered write ports (port 1 wins on an address
//            collision), and a per-register busy scoreboard for hazard
//            detection. After reset, a sequencer zeroes the array.
// Ports    : clk, resetn (async active-low)
//            ready                   - high once the clear sequence finished
//            raddr/rdata/rbusy       - packed read ports (NRD lanes)
//            we0/waddr0/wdata0       - write port 0
//            we1/waddr1/wdata1       - write port 1 (priority on same address)
//            set_busy/set_addr       - mark a register busy
//            flush                   - clear every busy bit
// Options  : `define REGFILE_MP_BYPASS_EN enables same-cycle write-to-read
//            bypass while in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  ready,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic                  set_busy,
    input  logic [AW-1:0]         set_addr,
    input  logic                  flush
);

    localparam logic [0:0]    S_CLEAR = 1'b0;
    localparam logic [0:0]    S_RUN   = 1'b1;
    localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_run;
    logic w_wr0;
    logic w_wr1;
    logic w_set;

    assign w_run = (state_q == S_RUN);
    assign ready = w_run;

    // Register 0 is hard-wired to zero when ZERO_REG is set, so writes and
    // busy marks aimed at it are discarded.
    assign w_wr0 = w_run && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_wr1 = w_run && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign w_set = w_run && set_busy && !((ZERO_REG != 0) && (set_addr == '0));

    // ------------------------------------------------------------------
    // Clear sequencer: one array entry per cycle, then RUN until reset
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset; zeroed by the sequencer). The port 1
    // assignment comes last so that it wins a same-address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (w_wr0) begin
                mem_q[waddr0] <= wdata0;
            end
            if (w_wr1) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: flush > set > write-clear
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (w_run) begin
            if (flush) begin
                busy_d = '0;
            end else begin
                if (we0) begin
                    busy_d[waddr0] = 1'b0;
                end
                if (we1) begin
                    busy_d[waddr1] = 1'b0;
                end
                // Applied after the write-clears so that a new producer
                // issued in the same cycle keeps the register busy.
                if (w_set) begin
                    busy_d[set_addr] = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]     w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_ra = raddr[gi*AW +: AW];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_run) begin
                w_data = mem_q[w_ra];
                w_busy = busy_q[w_ra];
`ifdef REGFILE_MP_BYPASS_EN
                // A write in flight retires its producer this cycle. Only a
                // new producer issued at the same time keeps the register busy.
                if (we1 && (waddr1 == w_ra)) begin
                    w_data = wdata1;
                    w_busy = set_busy && (set_addr == w_ra);
                end else if (we0 && (waddr0 == w_ra)) begin
                    w_data = wdata0;
                    w_busy = set_busy && (set_addr == w_ra);
                end
`endif
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = w_data;
        assign rbusy[gi]                  = w_busy;
    end

endmodule
`default_nettype wire
